// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Sends one command byte from the host to a PS/2 device over the shared
// open-collector clock/data lines. It runs request-to-send, shifts start,
// data, parity and stop on device falling edges, checks the device ack bit,
// and then waits for both lines to return idle.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active low
//   ps2_c     PS/2 clock, driven 0 or released (Z)
//   ps2_d     PS/2 data, driven 0 or released (Z)
//   tx_start  one-cycle send request, honoured only while idle
//   tx_byte   byte to send, latched when tx_start is accepted
//   busy      high from acceptance until the block is idle again
//   tx_done   one-cycle pulse, byte sent and acknowledged
//   tx_err    one-cycle pulse, missing ack or timeout
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | lines released, waiting for tx_start
// INHIBIT   | clock held low for INHIBIT_CYCLES (request-to-send)
// START     | clock and data both low for one cycle
// SEND      | clock released, one frame bit presented per falling edge
// ACK       | stop bit out, sample device ack on the 11th falling edge
// WAIT_IDLE | ack seen, wait for clock and data both high
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        ps2_c,
    inout  wire        ps2_d,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int TimerMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TimerW   = $clog2(TimerMax + 1);
    localparam int FiltW    = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        ACK,
        WAIT_IDLE
    } stateT;

    stateT             state;
    logic [1:0]        cSync;
    logic [1:0]        dSync;
    logic [FiltW-1:0]  filtCnt;
    logic              cFilt;
    logic              cFiltD;
    logic              fallEdge;
    logic [TimerW-1:0] timer;
    logic [9:0]        shiftReg;
    logic [3:0]        bitCnt;
    logic              cLow;
    logic              dLow;

    assign ps2_c = cLow ? 1'b0 : 1'bz;
    assign ps2_d = dLow ? 1'b0 : 1'bz;

    assign fallEdge = cFiltD & ~cFilt;

    // Synchronizers and clock glitch filter. The filtered level only changes
    // after FILTER_LEN consecutive synchronized samples disagree with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cSync   <= 2'b11;
            dSync   <= 2'b11;
            filtCnt <= '0;
            cFilt   <= 1'b1;
            cFiltD  <= 1'b1;
        end else begin
            cSync  <= {cSync[0], ps2_c};
            dSync  <= {dSync[0], ps2_d};
            cFiltD <= cFilt;
            if (cSync[1] == cFilt) begin
                filtCnt <= '0;
            end else if (filtCnt == FiltW'(FILTER_LEN - 1)) begin
                cFilt   <= cSync[1];
                filtCnt <= '0;
            end else begin
                filtCnt <= filtCnt + 1'b1;
            end
        end
    end

    // One down-counter serves both the inhibit period and the inactivity
    // timeout; it is reloaded on every device falling edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            timer    <= '0;
            shiftReg <= '0;
            bitCnt   <= '0;
            cLow     <= 1'b0;
            dLow     <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                IDLE: begin
                    cLow <= 1'b0;
                    dLow <= 1'b0;
                    if (tx_start) begin
                        shiftReg <= {1'b1, ~^tx_byte, tx_byte};
                        bitCnt   <= '0;
                        timer    <= TimerW'(INHIBIT_CYCLES - 1);
                        cLow     <= 1'b1;
                        busy     <= 1'b1;
                        state    <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (timer == '0) begin
                        dLow  <= 1'b1;
                        state <= START;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                START: begin
                    cLow  <= 1'b0;
                    timer <= TimerW'(TIMEOUT_CYCLES - 1);
                    state <= SEND;
                end
                SEND: begin
                    if (fallEdge) begin
                        // A 1 is sent by releasing the line.
                        dLow     <= ~shiftReg[0];
                        shiftReg <= {1'b0, shiftReg[9:1]};
                        bitCnt   <= bitCnt + 1'b1;
                        timer    <= TimerW'(TIMEOUT_CYCLES - 1);
                        if (bitCnt == 4'd9) begin
                            state <= ACK;
                        end
                    end else if (timer == '0) begin
                        tx_err <= 1'b1;
                        busy   <= 1'b0;
                        cLow   <= 1'b0;
                        dLow   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ACK: begin
                    if (fallEdge) begin
                        if (!dSync[1]) begin
                            timer <= TimerW'(TIMEOUT_CYCLES - 1);
                            state <= WAIT_IDLE;
                        end else begin
                            tx_err <= 1'b1;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end
                    end else if (timer == '0) begin
                        tx_err <= 1'b1;
                        busy   <= 1'b0;
                        cLow   <= 1'b0;
                        dLow   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (cFilt && dSync[1]) begin
                        tx_done <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (timer == '0) begin
                        tx_err <= 1'b1;
                        busy   <= 1'b0;
                        cLow   <= 1'b0;
                        dLow   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    cLow  <= 1'b0;
                    dLow  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: an open-collector PS/2 device model clocks each
// frame, records the bit seen before every falling edge and compares the
// frame against one built from the byte, its odd parity and the framing rules.
module tb_ps2_host_tx;

    localparam int INHIBIT = 50;
    localparam int TIMEOUT = 2000;
    localparam int FILT    = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       busy;
    logic       tx_done;
    logic       tx_err;
    wire        ps2_c;
    wire        ps2_d;

    logic devClkLow  = 1'b0;
    logic devDataLow = 1'b0;

    assign ps2_c = devClkLow  ? 1'b0 : 1'bz;
    assign ps2_d = devDataLow ? 1'b0 : 1'bz;
    pullup (ps2_c);
    pullup (ps2_d);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FILTER_LEN    (FILT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2_c   (ps2_c),
        .ps2_d   (ps2_d),
        .tx_start(tx_start),
        .tx_byte (tx_byte),
        .busy    (busy),
        .tx_done (tx_done),
        .tx_err  (tx_err)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int doneCnt  = 0;
    int errCnt   = 0;
    int bothCnt  = 0;

    always @(negedge clk) begin
        if (tx_done === 1'b1) doneCnt++;
        if (tx_err === 1'b1) errCnt++;
        if (tx_done === 1'b1 && tx_err === 1'b1) bothCnt++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Device model: clocks one host-to-device frame with half period h.
    task automatic sendFrame(input logic [7:0] b, input bit doAck, input int abortAt,
                             input int glitchAt, input bit poke);
        int          h;
        int          lowCnt;
        int          dLowCnt;
        int          guard;
        int          d0;
        int          e0;
        logic        par;
        logic [10:0] got;
        logic [10:0] exp;

        h   = $urandom_range(40, 60);
        d0  = doneCnt;
        e0  = errCnt;
        par = (($countones(b) % 2) == 0);
        exp = {1'b1, par, b, 1'b0};
        got = '0;

        tx_byte  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_on_accept", 32'(busy), 32'd1);

        lowCnt  = 0;
        dLowCnt = 0;
        guard   = 0;
        while (ps2_c === 1'b0 && guard < INHIBIT + 20) begin
            lowCnt++;
            if (ps2_d === 1'b0) dLowCnt++;
            @(negedge clk);
            guard++;
        end
        check("rts_clock_low_cycles", 32'(lowCnt), 32'(INHIBIT + 1));
        check("rts_data_low_cycles", 32'(dLowCnt), 32'd1);

        for (int i = 1; i <= 11; i++) begin
            if (poke && i == 2) begin
                tx_byte  = 8'h00;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                waitCycles(h - 1);
            end else if (glitchAt == i) begin
                waitCycles(h / 2);
                devClkLow = 1'b1;
                waitCycles(3);
                devClkLow = 1'b0;
                waitCycles(h - h / 2 - 3);
            end else begin
                waitCycles(h);
            end
            got[i-1] = ps2_d;
            if (i == 11 && doAck) devDataLow = 1'b1;
            devClkLow = 1'b1;
            if (i == abortAt) begin
                waitCycles(20);
                check("pre_abort_data", 32'(ps2_d), 32'(exp[i]));
                rst = 1'b0;
                @(negedge clk);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_data_released", 32'(ps2_d), 32'd1);
                waitCycles(h);
                devClkLow = 1'b0;
                waitCycles(3);
                rst = 1'b1;
                waitCycles(60);
                check("abort_no_pulses", 32'(doneCnt - d0 + errCnt - e0), 32'd0);
                check("abort_clk_released", 32'(ps2_c), 32'd1);
                return;
            end
            waitCycles(h);
            devClkLow = 1'b0;
        end

        if (doAck) begin
            waitCycles(5);
            devDataLow = 1'b0;
        end
        guard = 0;
        while (doneCnt == d0 && errCnt == e0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        waitCycles(30);
        check("frame_bits", 32'(got), 32'(exp));
        check("done_pulses", 32'(doneCnt - d0), doAck ? 32'd1 : 32'd0);
        check("err_pulses", 32'(errCnt - e0), doAck ? 32'd0 : 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("clk_released", 32'(ps2_c), 32'd1);
        check("data_released", 32'(ps2_d), 32'd1);
    endtask

    // Device never clocks: the error must land TIMEOUT cycles after SEND starts.
    task automatic timeoutFrame();
        int guard;
        int k;
        int d0;
        int e0;

        d0       = doneCnt;
        e0       = errCnt;
        tx_byte  = 8'hF4;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        guard = 0;
        while (ps2_c === 1'b0 && guard < INHIBIT + 20) begin
            @(negedge clk);
            guard++;
        end
        k = 0;
        while (tx_err !== 1'b1 && k < TIMEOUT + 50) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", 32'(k), 32'(TIMEOUT));
        check("timeout_clk_released", 32'(ps2_c), 32'd1);
        check("timeout_data_released", 32'(ps2_d), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        waitCycles(20);
        check("timeout_err_pulses", 32'(errCnt - e0), 32'd1);
        check("timeout_done_pulses", 32'(doneCnt - d0), 32'd0);
    endtask

    initial begin
        logic [7:0] rb;

        rst = 1'b0;
        waitCycles(5);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(tx_done), 32'd0);
        check("reset_err", 32'(tx_err), 32'd0);
        check("reset_clk", 32'(ps2_c), 32'd1);
        check("reset_data", 32'(ps2_d), 32'd1);
        rst = 1'b1;
        waitCycles(5);

        sendFrame(8'hF4, 1'b1, 0, 0, 1'b0);
        sendFrame(8'hFF, 1'b1, 0, 0, 1'b0);
        sendFrame(8'h00, 1'b1, 0, 0, 1'b0);
        sendFrame(8'hF4, 1'b0, 0, 0, 1'b0);
        timeoutFrame();
        sendFrame(8'hF4, 1'b1, 4, 0, 1'b0);
        sendFrame(8'hF4, 1'b1, 0, 0, 1'b0);

        rb = 8'($urandom_range(1, 254));
        sendFrame(rb, 1'b1, 0, 3, 1'b1);
        for (int n = 0; n < 3; n++) begin
            rb = 8'($urandom);
            sendFrame(rb, 1'b1, 0, 0, 1'b0);
        end

        check("no_simultaneous_pulses", 32'(bothCnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 enable data reporting, 0xFF reset) from the FPGA host to the mouse over the shared open-collector PS/2 clock/data lines. It runs the request-to-send sequence, shifts data/parity/stop on device-generated clock edges, and checks the device's acknowledge bit. It shares `ps2_c`/`ps2_d` with the mouse receive path, which must ignore line activity while `busy` is high.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 5000: clk cycles `ps2_c` is held low for request-to-send (100 us at 50 MHz).
- `TIMEOUT_CYCLES`, 750000: max clk cycles between device falling edges, and for the final idle wait (15 ms at 50 MHz).
- `FILTER_LEN`, 8: consecutive equal synchronized samples required to accept a new `ps2_c` level.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-low.
- `ps2_c`  inout  1  PS/2 clock; block drives 0 or Z only.
- `ps2_d`  inout  1  PS/2 data; block drives 0 or Z only.
- `tx_start`  in  1  one-cycle request; sampled only in IDLE.
- `tx_byte`  in  8  byte to send; latched when `tx_start` is accepted.
- `busy`  out  1  high from acceptance until return to IDLE.
- `tx_done`  out  1  one-cycle pulse: byte sent and acknowledged.
- `tx_err`  out  1  one-cycle pulse: no ack or timeout.

## Operation
- Input conditioning: `ps2_c`, `ps2_d` pass through 2-FF synchronizers. `ps2_c` also passes a FILTER_LEN-sample glitch filter. Falling edge = filtered clock goes 1->0.
- Frame: start 0, D0..D7 LSB first, odd parity (parity bit = ~^byte), stop 1 (lines released), then device ack 0.
- States:
  - IDLE: lines Z. On `tx_start`: latch byte and parity into 10-bit shift register {stop, parity, D7..D0}, clear counters, go to INHIBIT.
  - INHIBIT: drive `ps2_c`=0 for INHIBIT_CYCLES. Then go to START.
  - START: drive `ps2_d`=0 and keep `ps2_c`=0 for 1 cycle. Then go to SEND.
  - SEND: release `ps2_c` and hold `ps2_d`=0 (start bit). On each falling edge, present the next shift-register bit: 0 is driven as 0, 1 is released (Z). Bit counter runs 0..9. After the 10th edge the stop bit is presented (Z). Go to ACK.
  - ACK: on the 11th falling edge sample synchronized `ps2_d`. If 0, go to WAIT_IDLE. If 1, pulse `tx_err` and go to IDLE.
  - WAIT_IDLE: wait until filtered clock and synchronized data are both 1. Then pulse `tx_done` and go to IDLE.
- Timeout: the counter is cleared on entering SEND and on every falling edge. It counts in SEND, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES: pulse `tx_err`, release both lines, go to IDLE.
- `tx_start` outside IDLE is ignored; there is no queue.
- `tx_done` and `tx_err` are mutually exclusive and never asserted in the same cycle.

## Timing
- Reset (rst=0 at a clk edge): state IDLE, both lines Z, `busy`=0, `tx_done`=0, `tx_err`=0, counters and shift register 0, filter state 1. A reset mid-transfer releases both lines on the same edge; no done/err pulse is issued.
- `tx_start` high in IDLE at edge N: `busy`=1 and `ps2_c` driven low from edge N+1.
- `ps2_c` low for exactly INHIBIT_CYCLES+1 cycles; `ps2_d` goes low on the last of those cycles.
- Data update latency after a pin falling edge: at most 2+FILTER_LEN+1 clk cycles. This is well inside the device's ~30-50 us clock-low phase.
- `busy` falls in the same cycle that `tx_done` or `tx_err` pulses.

## Test plan
- Send 0xF4 against an acking device model (10-16.7 kHz clock). Device samples on rising edges: start 0, data 0,0,1,0,1,1,1,1, parity 0, stop 1. Required: `tx_done` pulses once, `tx_err` stays 0, `busy` returns to 0.
- Send 0xFF, then 0x00. Required: parity bits 1 and 1 respectively, and ack accepted for both.
- Device model leaves data high at the 11th edge (no ack). Required: `tx_err` pulses once, no `tx_done`, both lines Z afterwards.
- Device never clocks after RTS. Required: `tx_err` fires exactly TIMEOUT_CYCLES cycles after entering SEND, and both lines are released.
- Assert rst=0 after the 4th falling edge. Required: lines Z on the next edge, `busy`=0, no pulses. A new 0xF4 sent afterwards completes normally.
- Pulse `tx_start` with 0x00 while `busy`=1, and inject a 3-cycle glitch on `ps2_c`. Required: the original byte is transmitted unchanged, the glitch causes no edge, and exactly one `tx_done` pulse occurs.
